ahb_master_mux: RTL and testbench

- Master-to-slave multiplexer that sits directly downstream of the bus arbiter.
- Uses the arbiter's Hmaster to route the granted master's address/control onto the shared bus in the address phase.
- Registers the owner on Hready so write data is steered from the correct master in the data phase.
- Polices handover: a newly selected master must not present SEQ as its first beat. Illegal SEQ is suppressed and counted.

---
 rtl/ahb_master_mux.sv | 135 +++++++++++++
 tb/tb_ahb_master_mux.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_mux.sv
// ahb_master_mux: routes the arbiter-granted master onto the shared AHB bus.
//   Address phase: Haddr/Htrans/Hwrite/Hsize/Hburst follow Hmaster combinationally.
//   Data phase:    Hwdata follows Hmaster_data, which is registered from Hmaster on Hready.
//   A newly selected master that leads with SEQ has that beat forced to IDLE.
//   Each suppressed beat that completes on Hready=1 adds one to handover_err_cnt,
//   which saturates at all-ones.
// Ports:
//   Hclk, Hresetn            clock, async active-low reset
//   Hmaster, Hready          owner index from the arbiter, global transfer-complete strobe
//   M_*                      per-master buses, master i in slice i
//   Haddr..Hburst, Hwdata    shared bus outputs
//   Hmaster_data             data-phase owner
//   dphase_valid             data phase holds a NONSEQ/SEQ transfer
//   handover_err_cnt         saturating count of suppressed SEQ beats
// Optional: define AHB_MASTER_MUX_LOCK_EN to add M_Hmastlock, Hmastlock and Hmastlock_data.
module ahb_master_mux #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                  Hclk,
    input  logic                  Hresetn,
    input  logic [1:0]            Hmaster,
    input  logic                  Hready,
    input  logic [4*ADDR_W-1:0]   M_Haddr,
    input  logic [7:0]            M_Htrans,
    input  logic [3:0]            M_Hwrite,
    input  logic [11:0]           M_Hsize,
    input  logic [11:0]           M_Hburst,
    input  logic [4*DATA_W-1:0]   M_Hwdata,
`ifdef AHB_MASTER_MUX_LOCK_EN
    input  logic [3:0]            M_Hmastlock,
    output logic                  Hmastlock,
    output logic                  Hmastlock_data,
`endif
    output logic [ADDR_W-1:0]     Haddr,
    output logic [1:0]            Htrans,
    output logic                  Hwrite,
    output logic [2:0]            Hsize,
    output logic [2:0]            Hburst,
    output logic [DATA_W-1:0]     Hwdata,
    output logic [1:0]            Hmaster_data,
    output logic                  dphase_valid,
    output logic [ERRCNT_W-1:0]   handover_err_cnt
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    // Per-master views of the flat input buses
    logic [ADDR_W-1:0] w_addr  [4];
    logic [DATA_W-1:0] w_wdata [4];
    logic [1:0]        w_trans [4];
    logic [2:0]        w_size  [4];
    logic [2:0]        w_burst [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_addr[gi]  = M_Haddr[gi*ADDR_W +: ADDR_W];
        assign w_wdata[gi] = M_Hwdata[gi*DATA_W +: DATA_W];
        assign w_trans[gi] = M_Htrans[gi*2 +: 2];
        assign w_size[gi]  = M_Hsize[gi*3 +: 3];
        assign w_burst[gi] = M_Hburst[gi*3 +: 3];
    end

    logic [1:0]          r_prev_master;
    logic                r_handover_flag;
    logic [1:0]          r_hmaster_data;
    logic                r_dphase_valid;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic [1:0] w_sel_trans;
    logic       w_in_handover;
    logic       w_suppress;
    logic [1:0] w_htrans;
    logic       w_flag_next;

    // Handover policing and address-phase transfer type
    always_comb begin
        w_sel_trans   = w_trans[Hmaster];
        w_in_handover = r_handover_flag || (Hmaster != r_prev_master);
        w_suppress    = w_in_handover && (w_sel_trans == TR_SEQ);
        w_htrans      = (!Hresetn || w_suppress) ? TR_IDLE : w_sel_trans;
        // Only a clean NONSEQ/IDLE beat ends the handover window; BUSY and SEQ keep it open
        w_flag_next   = w_in_handover && (w_sel_trans == TR_BUSY || w_sel_trans == TR_SEQ);
    end

    // Data-phase owner and handover state; wait states hold everything
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_prev_master   <= 2'd0;
            r_handover_flag <= 1'b0;
            r_hmaster_data  <= 2'd0;
            r_dphase_valid  <= 1'b0;
            r_err_cnt       <= '0;
        end else if (Hready) begin
            r_prev_master   <= Hmaster;
            r_handover_flag <= w_flag_next;
            r_hmaster_data  <= Hmaster;
            r_dphase_valid  <= w_htrans[1];
            if (w_suppress && (r_err_cnt != {ERRCNT_W{1'b1}}))
                r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign Haddr            = w_addr[Hmaster];
    assign Htrans           = w_htrans;
    assign Hwrite           = M_Hwrite[Hmaster];
    assign Hsize            = w_size[Hmaster];
    assign Hburst           = w_burst[Hmaster];
    assign Hwdata           = w_wdata[r_hmaster_data];
    assign Hmaster_data     = r_hmaster_data;
    assign dphase_valid     = r_dphase_valid;
    assign handover_err_cnt = r_err_cnt;

`ifdef AHB_MASTER_MUX_LOCK_EN
    logic r_lock_data;
    logic w_lock;

    assign w_lock = Hresetn && !w_suppress && M_Hmastlock[Hmaster];

    // Lock indication follows the address phase into the data phase
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)
            r_lock_data <= 1'b0;
        else if (Hready)
            r_lock_data <= w_lock;
    end

    assign Hmastlock      = w_lock;
    assign Hmastlock_data = r_lock_data;
`endif

endmodule

// File: tb/tb_ahb_master_mux.sv
// Directed bench for ahb_master_mux: routing, wait-state hold, handover suppression,
// counter saturation and asynchronous reset.
module tb_ahb_master_mux;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ERRCNT_W = 8;

    localparam logic [31:0] WD0 = 32'hD0D0_0000;
    localparam logic [31:0] WD1 = 32'hD0D0_0001;
    localparam logic [31:0] WD2 = 32'hD0D0_0002;
    localparam logic [31:0] WD3 = 32'hD0D0_0003;

    logic                Hclk = 1'b0;
    logic                Hresetn;
    logic [1:0]          Hmaster;
    logic                Hready;
    logic [4*ADDR_W-1:0] M_Haddr;
    logic [7:0]          M_Htrans;
    logic [3:0]          M_Hwrite;
    logic [11:0]         M_Hsize;
    logic [11:0]         M_Hburst;
    logic [4*DATA_W-1:0] M_Hwdata;
    logic [ADDR_W-1:0]   Haddr;
    logic [1:0]          Htrans;
    logic                Hwrite;
    logic [2:0]          Hsize;
    logic [2:0]          Hburst;
    logic [DATA_W-1:0]   Hwdata;
    logic [1:0]          Hmaster_data;
    logic                dphase_valid;
    logic [ERRCNT_W-1:0] handover_err_cnt;
`ifdef AHB_MASTER_MUX_LOCK_EN
    logic [3:0]          M_Hmastlock;
    logic                Hmastlock;
    logic                Hmastlock_data;
`endif

    logic [1:0] ta [4];
    logic [3:0] wr;

    int checks = 0;
    int errors = 0;

    always #5 Hclk = ~Hclk;

    assign M_Htrans = {ta[3], ta[2], ta[1], ta[0]};
    assign M_Hwrite = wr;
    assign M_Haddr  = {32'h0000_0D00, 32'h0000_1000, 32'h0000_0B00, 32'h0000_0A00};
    assign M_Hsize  = {3'd3, 3'd2, 3'd1, 3'd0};
    assign M_Hburst = {3'd1, 3'd3, 3'd5, 3'd7};
    assign M_Hwdata = {WD3, WD2, WD1, WD0};

    ahb_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERRCNT_W(ERRCNT_W)) dut (
        .Hclk             (Hclk),
        .Hresetn          (Hresetn),
        .Hmaster          (Hmaster),
        .Hready           (Hready),
        .M_Haddr          (M_Haddr),
        .M_Htrans         (M_Htrans),
        .M_Hwrite         (M_Hwrite),
        .M_Hsize          (M_Hsize),
        .M_Hburst         (M_Hburst),
        .M_Hwdata         (M_Hwdata),
`ifdef AHB_MASTER_MUX_LOCK_EN
        .M_Hmastlock      (M_Hmastlock),
        .Hmastlock        (Hmastlock),
        .Hmastlock_data   (Hmastlock_data),
`endif
        .Haddr            (Haddr),
        .Htrans           (Htrans),
        .Hwrite           (Hwrite),
        .Hsize            (Hsize),
        .Hburst           (Hburst),
        .Hwdata           (Hwdata),
        .Hmaster_data     (Hmaster_data),
        .dphase_valid     (dphase_valid),
        .handover_err_cnt (handover_err_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        Hresetn = 1'b0;
        Hmaster = 2'd0;
        Hready  = 1'b1;
        wr      = 4'b0000;
        for (int i = 0; i < 4; i++) ta[i] = 2'b00;
        ta[0] = 2'b10;
`ifdef AHB_MASTER_MUX_LOCK_EN
        M_Hmastlock = 4'b0000;
`endif
        #2;
        // Reset state: Htrans forced IDLE even though master 0 drives NONSEQ
        chk("rst_htrans", 64'(Htrans), 64'(2'b00));
        chk("rst_hmaster_data", 64'(Hmaster_data), 64'd0);
        chk("rst_dphase_valid", 64'(dphase_valid), 64'd0);
        chk("rst_errcnt", 64'(handover_err_cnt), 64'd0);
        chk("rst_hwdata", 64'(Hwdata), 64'(WD0));
        @(negedge Hclk);
        @(negedge Hclk);
        ta[0]   = 2'b00;
        Hresetn = 1'b1;
        tick();

        // Master 2 NONSEQ write to 0x1000
        @(negedge Hclk);
        Hmaster = 2'd2; ta[2] = 2'b10; wr = 4'b0100;
        #1;
        chk("m2_haddr", 64'(Haddr), 64'h1000);
        chk("m2_htrans", 64'(Htrans), 64'(2'b10));
        chk("m2_hwrite", 64'(Hwrite), 64'd1);
        chk("m2_hsize", 64'(Hsize), 64'd2);
        chk("m2_hburst", 64'(Hburst), 64'd3);
        tick();
        chk("m2_hmaster_data", 64'(Hmaster_data), 64'd2);
        chk("m2_dphase_valid", 64'(dphase_valid), 64'd1);
        chk("m2_hwdata", 64'(Hwdata), 64'(WD2));

        // Master 1 data phase held by 3 wait states while Hmaster moves to 3
        @(negedge Hclk);
        Hmaster = 2'd1; ta[2] = 2'b00; ta[1] = 2'b10;
        tick();
        @(negedge Hclk);
        Hready = 1'b0; Hmaster = 2'd3; ta[1] = 2'b00; ta[3] = 2'b10;
        #1;
        chk("ws_haddr_follows", 64'(Haddr), 64'h0D00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ws_hmaster_data", 64'(Hmaster_data), 64'd1);
            chk("ws_hwdata", 64'(Hwdata), 64'(WD1));
        end
        @(negedge Hclk);
        Hready = 1'b1;
        tick();
        chk("ws_end_hmaster_data", 64'(Hmaster_data), 64'd3);
        chk("ws_end_hwdata", 64'(Hwdata), 64'(WD3));
        chk("ws_end_dphase_valid", 64'(dphase_valid), 64'd1);

        // Handover 0 -> 1 with illegal SEQ
        @(negedge Hclk);
        Hmaster = 2'd0; ta[3] = 2'b00; ta[0] = 2'b10;
        tick();
        @(negedge Hclk);
        Hmaster = 2'd1; ta[0] = 2'b00; ta[1] = 2'b11;
        #1;
        chk("ho_seq_suppressed", 64'(Htrans), 64'(2'b00));
        tick();
        chk("ho_errcnt1", 64'(handover_err_cnt), 64'd1);
        chk("ho_dphase_valid0", 64'(dphase_valid), 64'd0);
        chk("ho_hmaster_data", 64'(Hmaster_data), 64'd1);
        // Flag still set: a second SEQ from the same master is also suppressed
        @(negedge Hclk);
        #1;
        chk("ho_flag_seq", 64'(Htrans), 64'(2'b00));
        tick();
        chk("ho_errcnt2", 64'(handover_err_cnt), 64'd2);
        @(negedge Hclk);
        ta[1] = 2'b10;
        #1;
        chk("ho_nonseq_pass", 64'(Htrans), 64'(2'b10));
        tick();
        chk("ho_nonseq_dv", 64'(dphase_valid), 64'd1);
        chk("ho_nonseq_cnt", 64'(handover_err_cnt), 64'd2);
        // Flag cleared: SEQ is now legal
        @(negedge Hclk);
        ta[1] = 2'b11;
        #1;
        chk("ho_seq_legal", 64'(Htrans), 64'(2'b11));
        tick();
        chk("ho_seq_legal_cnt", 64'(handover_err_cnt), 64'd2);

        // BUSY on handover passes, keeps the window open
        @(negedge Hclk);
        Hmaster = 2'd2; ta[1] = 2'b00; ta[2] = 2'b01;
        #1;
        chk("busy_pass", 64'(Htrans), 64'(2'b01));
        tick();
        chk("busy_dv", 64'(dphase_valid), 64'd0);
        chk("busy_cnt", 64'(handover_err_cnt), 64'd2);
        @(negedge Hclk);
        ta[2] = 2'b11;
        #1;
        chk("busy_then_seq", 64'(Htrans), 64'(2'b00));
        tick();
        chk("busy_then_seq_cnt", 64'(handover_err_cnt), 64'd3);
        @(negedge Hclk);
        ta[2] = 2'b10;
        tick();

        // Suppression during a wait state: no count until Hready
        @(negedge Hclk);
        Hready = 1'b0; Hmaster = 2'd3; ta[2] = 2'b00; ta[3] = 2'b11;
        #1;
        chk("ws_seq_suppressed", 64'(Htrans), 64'(2'b00));
        tick();
        chk("ws_seq_nocount", 64'(handover_err_cnt), 64'd3);
        @(negedge Hclk);
        Hready = 1'b1;
        #1;
        chk("ws_seq_ready", 64'(Htrans), 64'(2'b00));
        tick();
        chk("ws_seq_count", 64'(handover_err_cnt), 64'd4);

        // 300 illegal handovers: counter saturates at 255
        @(negedge Hclk);
        ta[3] = 2'b00; ta[0] = 2'b11; ta[1] = 2'b11;
        for (int i = 0; i < 300; i++) begin
            if (i != 0) @(negedge Hclk);
            Hmaster = (i % 2 == 0) ? 2'd1 : 2'd0;
            tick();
            if (i == 99) chk("sat_mid", 64'(handover_err_cnt), 64'd104);
        end
        chk("sat_255", 64'(handover_err_cnt), 64'd255);

        // Reset mid-burst
        @(negedge Hclk);
        Hmaster = 2'd3; ta[0] = 2'b00; ta[1] = 2'b00; ta[3] = 2'b10;
        tick();
        chk("mid_hmaster_data3", 64'(Hmaster_data), 64'd3);
        chk("mid_dv1", 64'(dphase_valid), 64'd1);
        #1;
        Hresetn = 1'b0;
        #1;
        chk("arst_hmaster_data", 64'(Hmaster_data), 64'd0);
        chk("arst_dv", 64'(dphase_valid), 64'd0);
        chk("arst_htrans", 64'(Htrans), 64'(2'b00));
        chk("arst_errcnt", 64'(handover_err_cnt), 64'd0);
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1;
        chk("rel_hwdata_m0", 64'(Hwdata), 64'(WD0));
        chk("rel_htrans", 64'(Htrans), 64'(2'b10));
        tick();
        chk("rel_hmaster_data", 64'(Hmaster_data), 64'd3);

`ifdef AHB_MASTER_MUX_LOCK_EN
        @(negedge Hclk);
        Hmaster = 2'd2; ta[3] = 2'b00; ta[2] = 2'b10; M_Hmastlock = 4'b0100;
        #1;
        chk("lock_comb", 64'(Hmastlock), 64'd1);
        tick();
        chk("lock_data", 64'(Hmastlock_data), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
